button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 166 ++++++++++++++++
 tb/tb_button_conditioner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Push-button front end for the game (A/B/C move and fire,
//               D start/restart). Each raw active-low button goes through a
//               two-flop synchroniser and then a per-bit debounce counter.
//               The block outputs a clean active-high level and single-cycle
//               press/release pulses.
//               Optional auto-repeat is enabled with the macro
//               BTN_AUTOREPEAT_EN. When it is defined, held buttons selected
//               by REPEAT_MASK also emit periodic press pulses.
// Ports       : clk           - system clock
//               reset         - synchronous, active-high reset
//               btn_n         - raw buttons, active-low, asynchronous to clk
//               level         - debounced state, 1 = held
//               press         - one-cycle pulse on an accepted press / repeat
//               release_pulse - one-cycle pulse on an accepted release
//                               ("release" is a reserved word in
//                               SystemVerilog, hence the longer name)
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int               N_BTN           = 4,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter int               REPEAT_DELAY    = 25000000,
    parameter int               REPEAT_PERIOD   = 5000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b0011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse
);

    localparam int              c_DW      = $clog2(DEBOUNCE_CYCLES + 1);
    // Accept on the cycle the counter would reach DEBOUNCE_CYCLES.
    localparam logic [c_DW-1:0] c_DB_LAST = c_DW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int              c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              c_RW      = $clog2(c_REP_MAX + 1);
    localparam logic [c_RW-1:0] c_RD_LAST = c_RW'(REPEAT_DELAY - 1);
    localparam logic [c_RW-1:0] c_RP_LAST = c_RW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DELAY  = 2'd1;
    localparam logic [1:0] c_REPEAT = 2'd2;
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic            r_s1;
        logic            r_s2;
        logic            r_level;
        logic            r_press;
        logic            r_release;
        logic [c_DW-1:0] r_cnt;
        logic            w_p;
        logic            w_accept;
        logic            w_rise;
        logic            w_fall;
        logic            w_rep_pulse;

        // Synchronised sample, converted to active-high.
        assign w_p      = ~r_s2;
        assign w_accept = (w_p != r_level) && (r_cnt == c_DB_LAST);
        assign w_rise   = w_accept & w_p;
        assign w_fall   = w_accept & ~w_p;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_s1      <= 1'b1;
                r_s2      <= 1'b1;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_s1 <= btn_n[i];
                r_s2 <= r_s1;
                // Any sample agreeing with the current level restarts the
                // count, so a short bounce never produces a change.
                if (w_p == r_level) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt   <= '0;
                    r_level <= ~r_level;
                end else begin
                    r_cnt <= r_cnt + c_DW'(1);
                end
                r_press   <= w_rise | w_rep_pulse;
                r_release <= w_fall;
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        if (REPEAT_MASK[i]) begin : g_rep
            logic [1:0]      r_state;
            logic [c_RW-1:0] r_rcnt;
            logic            w_rep_hit;

            always_comb begin
                w_rep_hit = 1'b0;
                if ((r_state == c_DELAY) && (r_rcnt == c_RD_LAST)) begin
                    w_rep_hit = 1'b1;
                end
                if ((r_state == c_REPEAT) && (r_rcnt == c_RP_LAST)) begin
                    w_rep_hit = 1'b1;
                end
            end

            // A release in the same cycle wins over a due repeat pulse.
            assign w_rep_pulse = w_rep_hit & ~w_fall;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= c_IDLE;
                    r_rcnt  <= '0;
                end else if (w_fall) begin
                    r_state <= c_IDLE;
                    r_rcnt  <= '0;
                end else begin
                    case (r_state)
                        c_IDLE: begin
                            r_rcnt <= '0;
                            if (w_rise) begin
                                r_state <= c_DELAY;
                            end
                        end
                        c_DELAY: begin
                            if (w_rep_hit) begin
                                r_rcnt  <= '0;
                                r_state <= c_REPEAT;
                            end else begin
                                r_rcnt <= r_rcnt + c_RW'(1);
                            end
                        end
                        c_REPEAT: begin
                            if (w_rep_hit) begin
                                r_rcnt <= '0;
                            end else begin
                                r_rcnt <= r_rcnt + c_RW'(1);
                            end
                        end
                        default: begin
                            r_state <= c_IDLE;
                            r_rcnt  <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_norep
            assign w_rep_pulse = 1'b0;
        end
`else
        assign w_rep_pulse = 1'b0;
`endif

        assign level[i]         = r_level;
        assign press[i]         = r_press;
        assign release_pulse[i] = r_release;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
module tb_button_conditioner;

    localparam int         NB   = 4;
    localparam int         D    = 4;
    localparam int         RD   = 10;
    localparam int         RP   = 3;
    localparam logic [3:0] MASK = 4'b0011;
`ifdef BTN_AUTOREPEAT_EN
    localparam logic       REP0 = 1'b1;
`else
    localparam logic       REP0 = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_n = 4'hF;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] release_pulse;

    button_conditioner #(
        .N_BTN          (NB),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_n        (btn_n),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: level toggles once the last D synchronised
    // samples (raw value two edges old, inverted) all disagree with it.
    // Repeat pulses follow from the age of the current hold.
    // ------------------------------------------------------------------
    logic [3:0] raw_q[$];
    logic [3:0] m_level = '0;
    logic [3:0] m_press = '0;
    logic [3:0] m_rel   = '0;
    int         age[NB];
    bit         m_all;
    bit         chk_en = 1'b0;

    function automatic bit rep_on(input int b);
`ifdef BTN_AUTOREPEAT_EN
        return MASK[b];
`else
        return (b < 0);
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            raw_q.delete();
            for (int k = 0; k < D + 2; k++) raw_q.push_back(4'hF);
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
            for (int b = 0; b < NB; b++) age[b] = 0;
        end else begin
            raw_q.push_front(btn_n);
            void'(raw_q.pop_back());
            m_press = '0;
            m_rel   = '0;
            for (int b = 0; b < NB; b++) begin
                m_all = 1'b1;
                for (int j = 0; j < D; j++)
                    if ((~raw_q[2 + j][b]) == m_level[b]) m_all = 1'b0;
                if (m_all) begin
                    if (m_level[b]) m_rel[b] = 1'b1;
                    else begin
                        m_press[b] = 1'b1;
                        age[b]     = 0;
                    end
                    m_level[b] = ~m_level[b];
                end else if (m_level[b]) begin
                    age[b]++;
                    if (rep_on(b) && (age[b] == RD || (age[b] > RD && (age[b] - RD) % RP == 0)))
                        m_press[b] = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("level_vs_model", level, m_level);
            check("press_vs_model", press, m_press);
            check("release_vs_model", release_pulse, m_rel);
            check("press_release_exclusive", press & release_pulse, 0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    int cnt;
    int dur[NB];

    initial begin
        reset = 1'b1;
        btn_n = 4'hF;
        step(3);
        chk_en = 1'b1;
        check("reset_level", level, 0);
        check("reset_press", press, 0);
        check("reset_release", release_pulse, 0);
        reset = 1'b0;
        step(10);

        // Clean press on A, held, then released.
        btn_n = 4'b1110;
        step(5);
        check("clean_level_edge4", level[0], 0);
        check("clean_press_edge4", press[0], 0);
        step(1);
        check("clean_level_edge5", level[0], 1);
        check("clean_press_edge5", press[0], 1);
        check("clean_release_edge5", release_pulse[0], 0);
        step(1);
        check("clean_press_edge6", press[0], 0);
        step(8);
        check("hold_press_edge14", press[0], 0);
        step(1);
        check("hold_press_edge15", press[0], REP0);
        step(1);
        check("hold_press_edge16", press[0], 0);
        step(2);
        check("hold_press_edge18", press[0], REP0);
        btn_n = 4'hF;
        step(5);
        check("rel_level_before", level[0], 1);
        step(1);
        check("rel_release_pulse", release_pulse[0], 1);
        check("rel_press_suppressed", press[0], 0);
        check("rel_level_after", level[0], 0);
        cnt = 0;
        repeat (15) begin
            step(1);
            if (press[0]) cnt++;
        end
        check("no_press_after_release", cnt, 0);

        // Bounce on B: low 3, high 1, then low and held.
        cnt = 0;
        btn_n[1] = 1'b0;
        repeat (3) begin step(1); if (press[1]) cnt++; end
        btn_n[1] = 1'b1;
        step(1);
        if (press[1]) cnt++;
        btn_n[1] = 1'b0;
        repeat (5) begin step(1); if (press[1]) cnt++; end
        check("bounce_no_early_press", cnt, 0);
        check("bounce_level_early", level[1], 0);
        step(1);
        check("bounce_level_accept", level[1], 1);
        check("bounce_press_accept", press[1], 1);
        cnt = 0;
        repeat (8) begin step(1); if (press[1]) cnt++; end
        check("bounce_single_press", cnt, 0);
        btn_n = 4'hF;
        step(12);

        // C and D together, released together 20 cycles later.
        btn_n = 4'b0011;
        step(5);
        check("sim_level_early", level[3:2], 0);
        step(1);
        check("sim_press", press[3:2], 2'b11);
        check("sim_level", level[3:2], 2'b11);
        cnt = 0;
        repeat (14) begin step(1); if (|press[3:2]) cnt++; end
        check("sim_no_repeat", cnt, 0);
        btn_n = 4'hF;
        step(5);
        check("sim_release_early", release_pulse[3:2], 0);
        step(1);
        check("sim_release", release_pulse[3:2], 2'b11);
        check("sim_release_no_press", press[3:2], 0);
        step(10);

        // Reset mid-debounce while A is held.
        btn_n = 4'b1110;
        step(3);
        reset = 1'b1;
        step(1);
        check("rst_db_level", level, 0);
        check("rst_db_press", press, 0);
        check("rst_db_release", release_pulse, 0);
        step(1);
        reset = 1'b0;
        step(5);
        check("rst_db_press_early", press[0], 0);
        step(1);
        check("rst_db_press_after", press[0], 1);
        check("rst_db_level_after", level[0], 1);

        // Reset mid-repeat while A stays held.
        step(12);
        reset = 1'b1;
        step(1);
        check("rst_rep_level", level, 0);
        check("rst_rep_press", press, 0);
        check("rst_rep_release", release_pulse, 0);
        reset = 1'b0;
        step(5);
        check("rst_rep_press_early", press[0], 0);
        step(1);
        check("rst_rep_press_after", press[0], 1);
        btn_n = 4'hF;
        step(10);

        // Randomised phase: mixed long holds and short bounces, rare resets.
        for (int b = 0; b < NB; b++) dur[b] = int'($urandom_range(1, 20));
        repeat (3000) begin
            for (int b = 0; b < NB; b++) begin
                dur[b] = dur[b] - 1;
                if (dur[b] <= 0) begin
                    btn_n[b] = ~btn_n[b];
                    if ($urandom_range(0, 3) == 0) dur[b] = int'($urandom_range(1, 3));
                    else dur[b] = int'($urandom_range(4, 30));
                end
            end
            reset = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset = 1'b0;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
